param_bank: RTL
===============

# param_bank

Multi-channel, double-buffered bank of 32-bit run-time parameters loaded over the host interface. It generalises the per-signal triggered-input registers (lce, gamma, damping coefficients, clock divider) into one block. Each channel's 32-bit value is assembled from two 16-bit wire-ins on that channel's trigger pulse and held in a shadow register. Pending values are then committed to the active outputs together, so a spindle or neuron never sees a half-updated parameter set within one simulation step.

## Interface
Parameters:
- NCH, 8: number of parameter channels (1..16).
- RESET_VALUES, all zero: NCH×32-bit vector. Channel k's reset value is bits [32k+31:32k].
- KEEP_MASK, 0: NCH-bit mask. A set bit means the channel keeps its value on every reset except the first one after configuration.
- STAGED, 1: 1 means loads wait for `commit`; 0 means loads go straight to active.

Ports (clock and reset first):
- clk, input, 1: single clock. All state is on its rising edge.
- reset, input, 1: synchronous, active-high.
- trig, input, NCH: one-cycle load strobes, one per channel, already synchronous to clk.
- wire_lo, input, 16: low half of the load word.
- wire_hi, input, 16: high half of the load word.
- commit, input, 1: one-cycle strobe, typically the simulation-step tick.
- rd_sel, input, 4: readback channel select.
- params, output, NCH×32: active values, with channel k at [32k+31:32k].
- pending, output, NCH: shadow holds an uncommitted value.
- rd_data, output, 32: active value of the selected channel.
- commit_cnt, output, 16: number of commits that moved at least one channel.
- reject_cnt, output, 16: number of rejected loads. Present only with the macro (see Configuration).

## Operation
- Load: when trig[k]=1, shadow[k] ← {wire_hi, wire_lo}.
  - STAGED=1: pending[k] ← 1.
  - STAGED=0: active[k] ← {wire_hi, wire_lo} in the same cycle, and pending stays 0.
- Several trig bits high in one cycle: every selected channel loads the same word.
- Commit (STAGED=1): on commit=1, every channel with pending=1 copies shadow to active and clears pending.
  - commit_cnt increments only if any pending bit was set. It wraps 0xFFFF → 0.
- trig[k] and commit in the same cycle:
  - The commit moves the old shadow[k] to active[k].
  - The new word lands in shadow[k], and pending[k] stays 1.
- commit with no pending bits: no change, and the counter does not move.
- Reset, first-reset tracking: a `primed` flag powers up at 0 and is set by the first reset.
- Reset, channel values:
  - Channels with KEEP_MASK[k]=0 reload RESET_VALUES[k] into both active and shadow.
  - Channels with KEEP_MASK[k]=1 do the same only while primed=0. After that they hold their active value, and shadow is set equal to active.
- Reset, counters and flags: pending ← 0, commit_cnt ← 0, reject_cnt ← 0.
- Reset has priority over trig and commit in the same cycle.
- Reset in the middle of staging: all pending loads are discarded.
- Readback: rd_data is registered and shows active[rd_sel]. If rd_sel ≥ NCH, rd_data = 0.

## Timing
- trig at cycle n: shadow and pending are updated at n+1. With STAGED=0, params is also updated at n+1.
- commit at cycle m: params, pending and commit_cnt are updated at m+1.
- rd_data lags the rd_sel and params it reflects by 1 cycle.
- Reset asserted at cycle r: all outputs hold their reset values from r+1. rd_data shows the reset values from r+2.
- No handshake: every strobe is accepted in its cycle, and there is no back-pressure.

## Configuration
- Macro: PARAM_BANK_NAN_REJECT_EN.
- Defined:
  - A load whose word has exponent bits [30:23] = 8'hFF (IEEE-754 NaN or Inf) is dropped. Shadow and pending are unchanged.
  - reject_cnt increments by 1 per rejecting cycle, whatever the number of trig bits, and wraps.
- Not defined: every word is accepted, the reject_cnt port is absent, and there is no comparator logic.

## Structure
- Package param_bank_pkg holds:
  - the word width constant PB_DW = 32;
  - the counter width PB_CW = 16;
  - the function pb_is_nonfinite(word);
  - the helper that slices channel k out of a flattened vector.
- Sub-module param_bank_chan holds one channel: shadow, active and pending, keep/primed handling, and the commit copy. It is instantiated NCH times by generate.
- The top level holds the primed flag, the counters, the readback mux and reject detection.

## Test plan
- Reset with RESET_VALUES ch1 = 32'h42A00000, then trig[1] with {hi,lo} = {16'h3F8C, 16'hCCCD}, STAGED=1, no commit:
  - params ch1 stays 42A00000 and pending[1] = 1.
  - After commit, params ch1 = 3F8CCCCD, pending = 0 and commit_cnt = 1.
- trig[2] and commit in the same cycle, with shadow[2] already pending 3E714120 and new word 3D144674:
  - active[2] = 3E714120 and pending[2] = 1.
  - The next commit gives 3D144674.
- KEEP_MASK bit 6 set, ch6 committed to 0000_0100, then a second reset:
  - ch6 stays 0000_0100 and the other channels return to their defaults.
  - On the first reset after configuration, ch6 takes its default.
- Macro defined, trig[0] with word 7FC00000:
  - No change to shadow[0] or pending, and reject_cnt = 1.
  - A load of 3F800000 is then accepted.
- Readback:
  - rd_sel = 3 gives rd_data = active[3] one cycle later.
  - rd_sel = 12 with NCH = 8 gives rd_data = 0.
- commit_cnt with 65536 effective commits: it reads 0. Commits with nothing pending: the count is unchanged.

Source files
------------

// File: rtl/param_bank_pkg.sv
// Shared widths and helpers for the param_bank parameter store.
package param_bank_pkg;

  localparam int PB_DW     = 32;
  localparam int PB_CW     = 16;
  localparam int PB_MAX_CH = 16;
  localparam int PB_VW     = PB_MAX_CH * PB_DW;

  // Exponent all-ones marks an IEEE-754 single as NaN or infinity.
  function automatic logic pb_is_nonfinite(input logic [PB_DW-1:0] word);
    return &word[30:23];
  endfunction

  // Channel k of a flattened vector padded to the maximum channel count.
  function automatic logic [PB_DW-1:0] pb_chan(input logic [PB_VW-1:0] vec,
                                               input logic [3:0] k);
    return vec[{k, 5'd0} +: PB_DW];
  endfunction

endpackage

// File: rtl/param_bank_if.sv
// Host-side load/commit/readback bundle for param_bank.
// reject_cnt exists only when PARAM_BANK_NAN_REJECT_EN is defined.
interface param_bank_if #(
  parameter int NCH = 8
);
  import param_bank_pkg::*;

  logic [NCH-1:0]       trig;
  logic [15:0]          wire_lo;
  logic [15:0]          wire_hi;
  logic                 commit;
  logic [3:0]           rd_sel;
  logic [NCH*PB_DW-1:0] params;
  logic [NCH-1:0]       pending;
  logic [PB_DW-1:0]     rd_data;
  logic [PB_CW-1:0]     commit_cnt;
`ifdef PARAM_BANK_NAN_REJECT_EN
  logic [PB_CW-1:0]     reject_cnt;
`endif

  modport master (
    output trig, wire_lo, wire_hi, commit, rd_sel,
`ifdef PARAM_BANK_NAN_REJECT_EN
    input  reject_cnt,
`endif
    input  params, pending, rd_data, commit_cnt
  );

  modport slave (
    input  trig, wire_lo, wire_hi, commit, rd_sel,
`ifdef PARAM_BANK_NAN_REJECT_EN
    output reject_cnt,
`endif
    output params, pending, rd_data, commit_cnt
  );

endinterface

// File: rtl/param_bank_chan.sv
// One double-buffered parameter channel: shadow, active, pending and
// the keep-across-reset behaviour.
module param_bank_chan
  import param_bank_pkg::*;
#(
  parameter logic [PB_DW-1:0] RESET_VALUE = '0,
  parameter bit               KEEP        = 1'b0,
  parameter bit               STAGED      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             primed,
  input  logic             load,
  input  logic             commit,
  input  logic [PB_DW-1:0] load_word,
  output logic [PB_DW-1:0] active,
  output logic             pending
);

  logic [PB_DW-1:0] shadow;
  logic             restore;

  assign restore = !KEEP || !primed;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      if (restore) begin
        active <= RESET_VALUE;
        shadow <= RESET_VALUE;
      end else begin
        shadow <= active;
      end
    end else if (STAGED) begin
      // NOTE: non-blocking assignment means the commit copies the pre-edge
      // shadow even when a new word lands in shadow on the same edge.
      if (commit && pending) active <= shadow;
      if (load) begin
        shadow  <= load_word;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end else if (load) begin
      shadow <= load_word;
      active <= load_word;
    end
  end

endmodule

// File: rtl/param_bank.sv
// Multi-channel double-buffered run-time parameter bank.
// Define PARAM_BANK_NAN_REJECT_EN to drop NaN/Inf loads and count them.
module param_bank
  import param_bank_pkg::*;
#(
  parameter int                   NCH          = 8,
  parameter logic [NCH*PB_DW-1:0] RESET_VALUES = '0,
  parameter logic [NCH-1:0]       KEEP_MASK    = '0,
  parameter bit                   STAGED       = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  param_bank_if.slave  bus
);

  // NOTE: primed must survive every reset, so its only initial value is the
  // configuration-time one given here rather than a reset assignment.
  logic             primed = 1'b0;
  logic [NCH-1:0]   load;
  logic [PB_DW-1:0] load_word;

  assign load_word = {bus.wire_hi, bus.wire_lo};

`ifdef PARAM_BANK_NAN_REJECT_EN
  logic reject;

  assign reject = (|bus.trig) && pb_is_nonfinite(load_word);
  assign load   = bus.trig & ~{NCH{reject}};

  always_ff @(posedge clk) begin
    if (reset)       bus.reject_cnt <= '0;
    else if (reject) bus.reject_cnt <= bus.reject_cnt + PB_CW'(1);
  end
`else
  assign load = bus.trig;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    param_bank_chan #(
      .RESET_VALUE (pb_chan(PB_VW'(RESET_VALUES), 4'(k))),
      .KEEP        (KEEP_MASK[k]),
      .STAGED      (STAGED)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .primed    (primed),
      .load      (load[k]),
      .commit    (bus.commit),
      .load_word (load_word),
      .active    (bus.params[k*PB_DW +: PB_DW]),
      .pending   (bus.pending[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) primed <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.commit_cnt <= '0;
      bus.rd_data    <= '0;
    end else begin
      if (bus.commit && (|bus.pending)) bus.commit_cnt <= bus.commit_cnt + PB_CW'(1);
      bus.rd_data <= (int'(bus.rd_sel) < NCH) ? pb_chan(PB_VW'(bus.params), bus.rd_sel) : '0;
    end
  end

endmodule
